// File: rtl/sort_pkg.sv
// Shared definitions for the four_bit_sort_ctrl slice: data width, default
// frame depth and the controller state type.
package sort_pkg;

  localparam int DW            = 4;
  localparam int DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/four_bit_sort_ctrl_cmp.sv
// Combinational 4-bit unsigned magnitude comparator.
// Exactly one of eq, gr and lt is high for any pair of inputs.
module four_bit_sort_ctrl_cmp
  import sort_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          eq,
  output logic          gr,
  output logic          lt
);

  assign eq = (a == b);
  assign gr = (a >  b);
  assign lt = (a <  b);

endmodule

// File: rtl/four_bit_sort_ctrl.sv
// Frame sorter: loads DEPTH values, bubble-sorts them in place with one shared
// comparator (one adjacent compare per cycle), then streams them out ascending.
module four_bit_sort_ctrl
  import sort_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int CW    = $clog2(DEPTH*(DEPTH-1)/2+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic [CW-1:0] swap_cnt
);

  localparam int              IW        = $clog2(DEPTH);
  localparam logic [IW-1:0]   LAST_IDX  = IW'(DEPTH-1);
  localparam logic [IW-1:0]   LAST_PASS = IW'(DEPTH-2);

  state_e        state;
  logic [DW-1:0] mem [DEPTH];
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_b;
  logic [IW-1:0] pass;
  logic          swapped;
  logic          pass_end;
  logic          gr;
  logic          unused_eq;
  logic          unused_lt;

  // The second operand is clamped so that idx=DEPTH-1 (LOAD/DRAIN) never
  // addresses past the array; SORT never reaches that index.
  assign idx_b    = (idx == LAST_IDX) ? idx : idx + IW'(1);
  assign pass_end = (idx == LAST_PASS - pass);

  four_bit_sort_ctrl_cmp u_cmp (
    .a  (mem[idx]),
    .b  (mem[idx_b]),
    .eq (unused_eq),
    .gr (gr),
    .lt (unused_lt)
  );

  assign in_ready  = (state == LOAD);
  assign busy      = (state == SORT);
  assign out_valid = (state == DRAIN);
  assign out_data  = mem[idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= LOAD;
      idx      <= '0;
      pass     <= '0;
      swapped  <= 1'b0;
      swap_cnt <= '0;
      // NOTE: the array is only DEPTH flops, so it is cleared on reset; that
      // keeps out_data at 0 after reset. A RAM macro would not be reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            mem[idx] <= in_data;
            if (idx == LAST_IDX) begin
              state    <= SORT;
              idx      <= '0;
              pass     <= '0;
              swapped  <= 1'b0;
              swap_cnt <= '0;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end

        SORT: begin
          if (gr) begin
            // NOTE: non-blocking assignments both sample the old values, so
            // the two entries exchange without a temporary.
            mem[idx]   <= mem[idx_b];
            mem[idx_b] <= mem[idx];
            swap_cnt   <= swap_cnt + CW'(1);
          end
          if (pass_end) begin
            idx <= '0;
            if ((!swapped && !gr) || (pass == LAST_PASS)) begin
              state <= DRAIN;
            end else begin
              pass    <= pass + IW'(1);
              swapped <= 1'b0;
            end
          end else begin
            idx     <= idx + IW'(1);
            swapped <= swapped | gr;
          end
        end

        DRAIN: begin
          if (out_ready) begin
            if (idx == LAST_IDX) begin
              state <= LOAD;
              idx   <= '0;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end

        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_four_bit_sort_ctrl.sv
// Self-checking bench for four_bit_sort_ctrl: directed frames from the test
// plan plus randomized back-to-back frames against an inversion-count model.
module tb_four_bit_sort_ctrl;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  typedef logic [3:0] frame_t [DEPTH];

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_data = 4'd0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [3:0]    out_data;
  logic          busy;
  logic [CW-1:0] swap_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  four_bit_sort_ctrl #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .swap_cnt  (swap_cnt)
  );

  // Swaps of a stable bubble sort equal the strict inversion count. Each pass
  // lets exactly one larger element cross every element that still has one in
  // front of it, so the swapping passes equal the largest such count; one
  // extra clean pass follows unless the pass limit was reached.
  function automatic void model(input frame_t f, output frame_t s,
                                output int swaps, output int cycles);
    logic [3:0] q[$];
    int worst;
    int passes;
    int k;
    swaps = 0;
    worst = 0;
    for (int j = 0; j < DEPTH; j++) begin
      k = 0;
      for (int i = 0; i < j; i++) if (f[i] > f[j]) k++;
      swaps += k;
      if (k > worst) worst = k;
    end
    passes = (worst >= DEPTH-1) ? DEPTH-1 : worst + 1;
    cycles = 0;
    for (int p = 0; p < passes; p++) cycles += DEPTH-1-p;
    foreach (f[i]) q.push_back(f[i]);
    q.sort();
    for (int i = 0; i < DEPTH; i++) s[i] = q[i];
  endfunction

  // gaps: 0 = in_valid held high, 1 = idle cycle before every entry, 2 = random idles
  task automatic load_frame(input frame_t f, input int gaps, input string name);
    int t;
    for (int i = 0; i < DEPTH; i++) begin
      if (gaps == 1 || (gaps == 2 && $urandom_range(0, 1) == 1)) begin
        in_valid = 1'b0;
        in_data  = ~f[i];
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = f[i];
      t = 0;
      while (in_ready !== 1'b1 && t < 20) begin
        @(negedge clk);
        t++;
      end
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL %s load_ready[%0d]: got in_ready=%b want 1", name, i, in_ready);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic sort_and_drain(input frame_t f, input int stall_at, input int stall_len,
                                input bit rand_stall, input bit inject, input string name);
    frame_t s;
    int swaps;
    int cycles;
    int cyc;
    int t;
    int st;
    model(f, s, swaps, cycles);
    in_valid = inject;
    in_data  = 4'd9;

    n_cmp++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL %s sort_entry: got busy=%b in_ready=%b want busy=1 in_ready=0",
               name, busy, in_ready);
    end
    cyc = 0;
    while (busy === 1'b1 && cyc < 60) begin
      cyc++;
      @(negedge clk);
    end
    n_cmp++;
    if (cyc != cycles) begin
      n_bad++;
      $display("FAIL %s sort_cycles: got %0d want %0d", name, cyc, cycles);
    end
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL %s first_out_valid: got %b want 1", name, out_valid);
    end
    n_cmp++;
    if (swap_cnt !== CW'(swaps)) begin
      n_bad++;
      $display("FAIL %s swap_cnt: got %0d want %0d", name, swap_cnt, swaps);
    end

    for (int i = 0; i < DEPTH; i++) begin
      t = 0;
      while (out_valid !== 1'b1 && t < 20) begin
        @(negedge clk);
        t++;
      end
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== s[i]) begin
        n_bad++;
        $display("FAIL %s drain[%0d]: got valid=%b data=%0d want valid=1 data=%0d",
                 name, i, out_valid, out_data, s[i]);
      end
      st = 0;
      if (i == stall_at) st = stall_len;
      else if (rand_stall && $urandom_range(0, 3) == 0) st = $urandom_range(1, 2);
      out_ready = 1'b0;
      repeat (st) begin
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== s[i]) begin
          n_bad++;
          $display("FAIL %s drain_hold[%0d]: got valid=%b data=%0d want valid=1 data=%0d",
                   name, i, out_valid, out_data, s[i]);
        end
      end
      if (i == DEPTH-1) in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end

    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || swap_cnt !== CW'(swaps)) begin
      n_bad++;
      $display("FAIL %s after_drain: got in_ready=%b out_valid=%b busy=%b swap_cnt=%0d want 1 0 0 %0d",
               name, in_ready, out_valid, busy, swap_cnt, swaps);
    end
  endtask

  task automatic run_frame(input frame_t f, input int gaps, input int stall_at, input int stall_len,
                           input bit rand_stall, input bit inject, input string name);
    load_frame(f, gaps, name);
    sort_and_drain(f, stall_at, stall_len, rand_stall, inject, name);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 4'd0 ||
        busy !== 1'b0 || swap_cnt !== '0) begin
      n_bad++;
      $display("FAIL reset: got in_ready=%b out_valid=%b out_data=%0d busy=%b swap_cnt=%0d want 1 0 0 0 0",
               in_ready, out_valid, out_data, busy, swap_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reverse_mixed();
    frame_t f;
    f = '{4'd3, 4'd1, 4'd2, 4'd0};
    run_frame(f, 0, -1, 0, 1'b0, 1'b0, "mixed_3120");
  endtask

  task automatic test_presorted();
    frame_t f;
    f = '{4'd1, 4'd4, 4'd9, 4'd15};
    run_frame(f, 0, -1, 0, 1'b0, 1'b0, "sorted_1_4_9_15");
  endtask

  task automatic test_equal_values();
    frame_t f;
    f = '{4'd15, 4'd8, 4'd8, 4'd0};
    run_frame(f, 0, -1, 0, 1'b0, 1'b0, "equal_15_8_8_0");
  endtask

  task automatic test_gapped_stall();
    frame_t f;
    f = '{4'd5, 4'd5, 4'd5, 4'd5};
    run_frame(f, 1, 2, 3, 1'b0, 1'b0, "gapped_5555");
  endtask

  task automatic test_reset_mid_sort();
    frame_t f;
    f = '{4'd7, 4'd3, 4'd6, 4'd2};
    load_frame(f, 0, "reset_mid_sort");
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || swap_cnt !== CW'(2)) begin
      n_bad++;
      $display("FAIL reset_mid_sort pre: got busy=%b swap_cnt=%0d want 1 2", busy, swap_cnt);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_sort async: got in_ready=%b busy=%b want 1 0", in_ready, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || swap_cnt !== '0 ||
        out_valid !== 1'b0 || out_data !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_mid_sort post: got in_ready=%b busy=%b swap_cnt=%0d out_valid=%b out_data=%0d want 1 0 0 0 0",
               in_ready, busy, swap_cnt, out_valid, out_data);
    end
    rst = 1'b0;
    @(negedge clk);
    f = '{4'd2, 4'd1, 4'd0, 4'd3};
    run_frame(f, 0, -1, 0, 1'b0, 1'b0, "after_reset_2103");
  endtask

  task automatic test_ignored_inputs();
    frame_t f;
    f = '{4'd12, 4'd0, 4'd4, 4'd7};
    run_frame(f, 0, 1, 2, 1'b0, 1'b1, "inject_9");
  endtask

  task automatic test_back_to_back();
    frame_t f;
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < DEPTH; i++)
        f[i] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(6, 8));
      run_frame(f, 2, -1, 0, 1'b1, ($urandom_range(0, 2) == 0), "random");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_reverse_mixed();
    test_presorted();
    test_equal_values();
    test_gapped_stall();
    test_reset_mid_sort();
    test_ignored_inputs();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
